// File: rtl/screen_pkg.sv
// Shared constants, state encoding and sizing helper for the screen frame-buffer scanner.
package screen_pkg;

  localparam int PIX_PER_WORD  = 16;
  localparam int WORDS_PER_ROW = 32;
  localparam int ROWS          = 256;
  localparam int SCREEN_WORDS  = WORDS_PER_ROW * ROWS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } scan_state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/screen_pos_counter.sv
// Bit / column / row position of the pixel currently presented, with frame-position markers.
module screen_pos_counter #(
  parameter int WORDS_PER_ROW = screen_pkg::WORDS_PER_ROW,
  parameter int ROWS          = screen_pkg::ROWS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic advance,
  output logic last_bit,
  output logic last_col,
  output logic last_row,
  output logic sof,
  output logic eol,
  output logic eof
);
  import screen_pkg::*;

  localparam int BIT_W = cnt_width(PIX_PER_WORD);
  localparam int COL_W = cnt_width(WORDS_PER_ROW);
  localparam int ROW_W = cnt_width(ROWS);

  logic [BIT_W-1:0] bit_idx_reg, bit_idx_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;

  assign last_bit = (bit_idx_reg == BIT_W'(PIX_PER_WORD - 1));
  assign last_col = (col_reg == COL_W'(WORDS_PER_ROW - 1));
  assign last_row = (row_reg == ROW_W'(ROWS - 1));
  assign sof      = (bit_idx_reg == '0) && (col_reg == '0) && (row_reg == '0);
  assign eol      = last_bit && last_col;
  assign eof      = eol && last_row;

  always_comb begin
    bit_idx_next = bit_idx_reg;
    col_next     = col_reg;
    row_next     = row_reg;
    if (clear) begin
      bit_idx_next = '0;
      col_next     = '0;
      row_next     = '0;
    end else if (advance) begin
      if (last_bit) begin
        bit_idx_next = '0;
        // The end-of-frame advance wraps every counter back to (0,0,0).
        if (last_col) begin
          col_next = '0;
          row_next = last_row ? '0 : row_reg + 1'b1;
        end else begin
          col_next = col_reg + 1'b1;
        end
      end else begin
        bit_idx_next = bit_idx_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_idx_reg <= '0;
      col_reg     <= '0;
      row_reg     <= '0;
    end else begin
      bit_idx_reg <= bit_idx_next;
      col_reg     <= col_next;
      row_reg     <= row_next;
    end
  end

endmodule

// File: rtl/screen_scanner.sv
// Read-side master that walks the screen region of word memory and streams it
// out as 1-bit pixels over a valid/ready handshake.
module screen_scanner #(
  parameter int ADDR_W        = 14,
  parameter int BASE          = 0,
  parameter int WORDS_PER_ROW = screen_pkg::WORDS_PER_ROW,
  parameter int ROWS          = screen_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy
);
  import screen_pkg::*;

  localparam int FRAME_WORDS = WORDS_PER_ROW * ROWS;
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BASE + FRAME_WORDS - 1);

  scan_state_t state_reg, state_next;
  logic [PIX_PER_WORD-1:0] shreg_reg, shreg_next, shreg_shifted;
  logic [ADDR_W-1:0] rd_addr_reg, rd_addr_next;

  logic cnt_clear;
  logic cnt_advance;
  logic last_bit, last_col, last_row;
  logic pos_sof, pos_eol, pos_eof;

  // Step past the last screen word back to the start, never into the next region.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? BASE_ADDR : a + 1'b1;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_WORD; gi++) begin : g_shift
      if (gi == PIX_PER_WORD - 1) begin : g_top
        assign shreg_shifted[gi] = 1'b0;
      end else begin : g_mid
        assign shreg_shifted[gi] = shreg_reg[gi+1];
      end
    end
  endgenerate

  screen_pos_counter #(
    .WORDS_PER_ROW (WORDS_PER_ROW),
    .ROWS          (ROWS)
  ) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .advance  (cnt_advance),
    .last_bit (last_bit),
    .last_col (last_col),
    .last_row (last_row),
    .sof      (pos_sof),
    .eol      (pos_eol),
    .eof      (pos_eof)
  );

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    rd_addr_next = rd_addr_reg;
    cnt_clear    = 1'b0;
    cnt_advance  = 1'b0;
    case (state_reg)
      IDLE: begin
        rd_addr_next = BASE_ADDR;
        if (enable) begin
          shreg_next   = rd_data;
          rd_addr_next = next_addr(BASE_ADDR);
          cnt_clear    = 1'b1;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (pix_ready) begin
          cnt_advance = 1'b1;
          if (!last_bit) begin
            shreg_next = shreg_shifted;
          end else if (!pos_eof || enable) begin
            // At end of frame rd_addr has already wrapped to BASE, so this
            // reload doubles as the start of the next frame.
            shreg_next   = rd_data;
            rd_addr_next = next_addr(rd_addr_reg);
          end else begin
            shreg_next   = '0;
            rd_addr_next = BASE_ADDR;
            state_next   = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        rd_addr_next = BASE_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      rd_addr_reg <= BASE_ADDR;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      rd_addr_reg <= rd_addr_next;
    end
  end

  assign busy      = (state_reg == SHIFT);
  assign pix_valid = busy;
  assign pix_data  = busy & shreg_reg[0];
  assign pix_sof   = busy & pos_sof;
  assign pix_eol   = busy & pos_eol;
  assign pix_eof   = busy & pos_eof;
  assign rd_addr   = rd_addr_reg;

  // Low bits of last_col / last_row only feed the marker decode inside the counter.
  logic unused_pos;
  assign unused_pos = last_col ^ last_row;

endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner on a 4-row screen so full frames stay short;
// expected pixels come from the bench's own memory image.
module tb_screen_scanner;

  localparam int ADDR_W      = 14;
  localparam int BASE        = 0;
  localparam int WPR         = 32;
  localparam int NROWS       = 4;
  localparam int FRAME_WORDS = WPR * NROWS;
  localparam int FRAME       = FRAME_WORDS * 16;
  localparam int ROW_PIX     = WPR * 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              pix_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [15:0]       rd_data;
  logic              pix_data, pix_valid, pix_sof, pix_eol, pix_eof, busy;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  assign rd_data = mem[rd_addr];

  always #5 clk = ~clk;

  screen_scanner #(
    .ADDR_W        (ADDR_W),
    .BASE          (BASE),
    .WORDS_PER_ROW (WPR),
    .ROWS          (NROWS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;
  int hs    = 0;
  logic [15:0] cur_word = '0;
  logic [31:0] first_pix = 32'hFFFF_0005;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s hs=%0d got=%0h exp=%0h", tag, hs, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pixel();
    int p;
    int w;
    int b;
    p = hs % FRAME;
    w = p / 16;
    b = p % 16;
    if (b == 0) cur_word = mem[BASE + w];
    check_val("valid", 32'(pix_valid), 32'd1);
    check_val("busy", 32'(busy), 32'd1);
    check_val("data", 32'(pix_data), 32'(cur_word[b]));
    check_val("sof", 32'(pix_sof), 32'(p == 0));
    check_val("eol", 32'(pix_eol), 32'(p % ROW_PIX == ROW_PIX - 1));
    check_val("eof", 32'(pix_eof), 32'(p == FRAME - 1));
    check_val("rd_addr", 32'(rd_addr), 32'(BASE + ((w + 1) % FRAME_WORDS)));
    if (hs < 32) check_val("first32", 32'(pix_data), 32'(first_pix[hs]));
    if (p == ROW_PIX - 1) check_val("row_end_pix", 32'(pix_data), 32'd1);
    if (p == ROW_PIX) check_val("row_next_pix", 32'(pix_data), 32'd1);
  endtask

  task automatic step();
    check_pixel();
    tick();
    hs++;
  endtask

  task automatic stall(input int n);
    pix_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check_pixel();
    end
    pix_ready = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_addr"}, 32'(rd_addr), 32'(BASE));
    check_val({tag, "_marks"}, {29'd0, pix_sof, pix_eol, pix_eof}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++)
      mem[i] = 16'(i * 40503 + 4660);
    mem[0]  = 16'h0005;
    mem[1]  = 16'hFFFF;
    mem[31] = 16'h8000;
    mem[32] = 16'h0001;

    rst_n     = 1'b0;
    enable    = 1'b1;
    pix_ready = 1'b1;
    tick();
    check_idle("reset1");
    tick();
    check_idle("reset2");
    $display("reset held 2 cycles with enable high");

    rst_n = 1'b1;
    tick();
    hs = 0;
    $display("scan started, first pixel presented");
    while (hs < 3) step();
    stall(5);
    $display("stall of 5 cycles on pixel 3 done");

    while (hs < 803) step();
    mem[51] = 16'hA5A5;
    mem[50] = ~mem[50];
    $display("wrote word 51 before its load and word 50 after its load");

    while (hs < FRAME + 1000) step();
    $display("first frame wrapped into second frame");
    enable = 1'b0;
    while (hs < 2 * FRAME) step();
    check_idle("stop");
    tick();
    check_idle("stop_hold");
    $display("enable dropped mid-frame, frame completed then idle");

    enable = 1'b1;
    tick();
    hs = 0;
    while (hs < 1500) step();
    rst_n = 1'b0;
    tick();
    check_idle("midrst");
    $display("reset applied mid-frame");
    rst_n = 1'b1;
    tick();
    hs = 0;
    while (hs < 40) step();
    $display("scan restarted cleanly after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
